// File: rtl/pwm_capture_pkg.sv
// Shared types and defaults for the PWM capture block.
package pwm_capture_pkg;

    localparam int CW_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HIGH,
        LOW
    } capState_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Control/result bundle between the capture block (slave) and the register wrapper (master).
interface pwm_capture_if
    import pwm_capture_pkg::*;
#(
    parameter int CW = CW_DEFAULT
);
    logic          en;
    logic          pwm_in;
    logic          inv;
    logic [3:0]    clkdiv;
    logic [CW-1:0] timeout;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          valid;
    logic          ovf;
    logic          stall;
    logic          stall_level;

    modport master (
        output en, pwm_in, inv, clkdiv, timeout,
        input  period, high_time, valid, ovf, stall, stall_level
    );

    modport slave (
        input  en, pwm_in, inv, clkdiv, timeout,
        output period, high_time, valid, ovf, stall, stall_level
    );
endinterface

// File: rtl/pwm_capture_sync.sv
// Input conditioning: 2-FF synchronizer, optional inversion and edge detection.
module pwm_capture_sync (
    input  logic clk,
    input  logic rst,
    input  logic pwmIn,
    input  logic inv,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [1:0] syncQ;
    logic       levelQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncQ  <= '0;
            levelQ <= 1'b0;
        end else begin
            syncQ  <= {syncQ[0], pwmIn};
            levelQ <= level;
        end
    end

    assign level = syncQ[1] ^ inv;
    assign rise  = level & ~levelQ;
    assign fall  = ~level & levelQ;
endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time measurement in prescaled ticks, with stall detection.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input logic          clk,
    input logic          rst,
    pwm_capture_if.slave bus
);
    localparam logic [CW-1:0] MAX = '1;

    capState_t state, nextState;

    logic level, rise, fall;
    logic [3:0]    divQ, preCnt, idlePre;
    logic [CW-1:0] tickCnt, idleCnt, highQ;
    logic          perSat, highSat;
    logic          tick, idleTick, measuring, timeoutHit;
    logic [CW-1:0] perVal;
    logic          perOvf;
    logic [CW:0]   idleVal;
    logic          clear, restart, measure, takeHigh, doStall;

    logic [CW-1:0] periodQ, highTimeQ;
    logic          validQ, ovfQ, stallQ, stallLevelQ;

    pwm_capture_sync uSync (
        .clk   (clk),
        .rst   (rst),
        .pwmIn (bus.pwm_in),
        .inv   (bus.inv),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // tickCnt + tick is floor(cycles since rise / (div+1)) as of this cycle.
    assign tick     = (preCnt == divQ);
    assign perVal   = (tickCnt == MAX) ? MAX : tickCnt + CW'(tick);
    assign perOvf   = perSat | (tick & (tickCnt == MAX));

    assign idleTick   = (idlePre == divQ);
    assign idleVal    = {1'b0, idleCnt} + (CW+1)'(idleTick);
    assign measuring  = (state == HIGH) || (state == LOW);
    assign timeoutHit = (bus.timeout != '0) && (idleVal >= {1'b0, bus.timeout});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (!bus.en) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE:    nextState = ARM;
                ARM:     if (rise) nextState = HIGH;
                HIGH:    if (fall) nextState = LOW;
                         else if (!rise && timeoutHit) nextState = ARM;
                LOW:     if (rise) nextState = HIGH;
                         else if (!fall && timeoutHit) nextState = ARM;
                default: nextState = IDLE;
            endcase
        end
    end

    // Any detected edge takes priority over a coincident timeout.
    always_comb begin
        clear    = 1'b0;
        restart  = 1'b0;
        measure  = 1'b0;
        takeHigh = 1'b0;
        doStall  = 1'b0;
        if (!bus.en || state == IDLE) begin
            clear = 1'b1;
        end else begin
            restart  = rise;
            measure  = rise && measuring;
            takeHigh = fall && (state == HIGH);
            doStall  = !rise && !fall && timeoutHit && measuring;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divQ    <= '0;
            preCnt  <= '0;
            tickCnt <= '0;
            perSat  <= 1'b0;
            idlePre <= '0;
            idleCnt <= '0;
            highQ   <= '0;
            highSat <= 1'b0;
        end else if (clear) begin
            divQ    <= bus.clkdiv;
            preCnt  <= '0;
            tickCnt <= '0;
            perSat  <= 1'b0;
            idlePre <= '0;
            idleCnt <= '0;
            highQ   <= '0;
            highSat <= 1'b0;
        end else begin
            if (restart) begin
                divQ    <= bus.clkdiv;
                preCnt  <= '0;
                tickCnt <= '0;
                perSat  <= 1'b0;
            end else if (tick) begin
                preCnt  <= '0;
                tickCnt <= perVal;
                perSat  <= perOvf;
            end else begin
                preCnt  <= preCnt + 4'd1;
            end

            if (rise || fall) begin
                idlePre <= '0;
                idleCnt <= '0;
            end else if (idleTick) begin
                idlePre <= '0;
                if (idleCnt != MAX) idleCnt <= idleCnt + CW'(1);
            end else begin
                idlePre <= idlePre + 4'd1;
            end

            if (takeHigh) begin
                highQ   <= perVal;
                highSat <= perOvf;
            end
        end
    end

    // A rise while still HIGH means the fall was missed: high time spans the whole period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            periodQ     <= '0;
            highTimeQ   <= '0;
            validQ      <= 1'b0;
            ovfQ        <= 1'b0;
            stallQ      <= 1'b0;
            stallLevelQ <= 1'b0;
        end else begin
            validQ <= measure;
            stallQ <= doStall;
            if (measure) begin
                periodQ   <= perVal;
                highTimeQ <= (state == HIGH) ? perVal : highQ;
                ovfQ      <= perOvf | ((state == LOW) & highSat);
            end
            if (doStall) stallLevelQ <= level;
        end
    end

    assign bus.period      = periodQ;
    assign bus.high_time   = highTimeQ;
    assign bus.valid       = validQ;
    assign bus.ovf         = ovfQ;
    assign bus.stall       = stallQ;
    assign bus.stall_level = stallLevelQ;
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a CW=32 and a CW=8 instance share one stimulus.
module tb_pwm_capture;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        pwmIn = 1'b0;
    logic        inv = 1'b0;
    logic [3:0]  clkdiv = 4'd0;
    logic [31:0] timeout = 32'd0;

    pwm_capture_if #(.CW(32)) ifA ();
    pwm_capture_if #(.CW(8))  ifB ();

    assign ifA.en = en;  assign ifA.pwm_in = pwmIn;  assign ifA.inv = inv;
    assign ifA.clkdiv = clkdiv;  assign ifA.timeout = timeout;
    assign ifB.en = en;  assign ifB.pwm_in = pwmIn;  assign ifB.inv = inv;
    assign ifB.clkdiv = clkdiv;  assign ifB.timeout = timeout[7:0];

    pwm_capture #(.CW(32)) dutA (.clk(clk), .rst(rst), .bus(ifA));
    pwm_capture #(.CW(8))  dutB (.clk(clk), .rst(rst), .bus(ifB));

    always #5 clk = ~clk;

    int nCmp = 0;
    int nBad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Event monitor samples 2 time units after each rising edge.
    int   cyc = 0;
    int   vCntA = 0, vLastA = 0, vGapA = 0, vFirstA = 0;
    int   sCntA = 0, sLastA = 0, vCntB = 0, bothCnt = 0;
    logic vArm = 1'b0;

    always @(posedge clk) begin
        cyc++;
        #2;
        if (ifA.valid) begin
            vCntA++;
            vGapA  = cyc - vLastA;
            vLastA = cyc;
            if (vArm) begin
                vFirstA = cyc;
                vArm    = 1'b0;
            end
        end
        if (ifA.stall) begin
            sCntA++;
            sLastA = cyc;
        end
        if (ifA.valid && ifA.stall) bothCnt++;
        if (ifB.valid) vCntB++;
    end

    int rise2 = 0;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            pwmIn = 1'b1;
            if (i == 1) begin
                rise2 = cyc;
                vArm  = 1'b1;
            end
            step(hi);
            pwmIn = 1'b0;
            step(lo);
        end
    endtask

    task automatic reEnable();
        en = 1'b0;
        step(3);
        en = 1'b1;
        step(3);
    endtask

    int bA, bB, sB, fc;

    initial begin
        step(2);
        chk("rst_period", ifA.period, 0);
        chk("rst_high", ifA.high_time, 0);
        chk("rst_valid", ifA.valid, 0);
        chk("rst_ovf", ifA.ovf, 0);
        chk("rst_stall", ifA.stall, 0);
        chk("rst_stall_level", ifA.stall_level, 0);
        rst = 1'b0;
        step(2);

        // 5 high / 8 low, no prescale
        en = 1'b1;
        step(3);
        bA = vCntA;
        wave(5, 8, 4);
        step(6);
        chk("t1_count", vCntA - bA, 3);
        chk("t1_period", ifA.period, 13);
        chk("t1_high", ifA.high_time, 5);
        chk("t1_ovf", ifA.ovf, 0);
        chk("t1_gap", vGapA, 13);
        chk("t1_latency", vFirstA - rise2, 3);

        // prescale by 4: 80 cycles -> 20 ticks, 20 high -> 5 ticks
        en = 1'b0; clkdiv = 4'd3; step(3); en = 1'b1; step(3);
        bA = vCntA;
        wave(20, 60, 3);
        step(6);
        chk("t2_count", vCntA - bA, 2);
        chk("t2_period", ifA.period, 20);
        chk("t2_high", ifA.high_time, 5);

        // inverted input: the 8-cycle low phase becomes the high time
        en = 1'b0; clkdiv = 4'd0; inv = 1'b1; step(3); en = 1'b1; step(3);
        bA = vCntA;
        wave(5, 8, 4);
        step(6);
        chk("t3_count", vCntA - bA, 3);
        chk("t3_period", ifA.period, 13);
        chk("t3_high", ifA.high_time, 8);

        // stall 50 ticks after the last fall, then re-arm
        en = 1'b0; inv = 1'b0; step(3); timeout = 32'd50; en = 1'b1; step(3);
        bA = vCntA;
        sB = sCntA;
        pwmIn = 1'b1;
        step(5);
        pwmIn = 1'b0;
        fc = cyc;
        step(80);
        chk("t4_stall_count", sCntA - sB, 1);
        chk("t4_stall_time", sLastA - fc, 53);
        chk("t4_stall_level", ifA.stall_level, 0);
        chk("t4_no_valid", vCntA - bA, 0);
        chk("t4_period_kept", ifA.period, 13);
        wave(5, 8, 2);
        step(4);
        timeout = 32'd0;
        chk("t4_resume_count", vCntA - bA, 1);
        chk("t4_resume_period", ifA.period, 13);

        // saturation on the narrow instance
        reEnable();
        bA = vCntA;
        bB = vCntB;
        wave(100, 200, 3);
        step(6);
        chk("t5_b_count", vCntB - bB, 2);
        chk("t5_b_period", ifB.period, 255);
        chk("t5_b_high", ifB.high_time, 100);
        chk("t5_b_ovf", ifB.ovf, 1);
        chk("t5_a_period", ifA.period, 300);
        chk("t5_a_high", ifA.high_time, 100);
        chk("t5_a_ovf", ifA.ovf, 0);
        wave(5, 8, 3);
        step(6);
        chk("t5_b_period2", ifB.period, 13);
        chk("t5_b_ovf2", ifB.ovf, 0);

        // disable mid-LOW: the pending measurement is dropped
        reEnable();
        wave(5, 8, 3);
        pwmIn = 1'b1;
        step(7);
        pwmIn = 1'b0;
        step(6);
        bA = vCntA;
        en = 1'b0;
        step(3);
        pwmIn = 1'b1;
        step(10);
        chk("t6_no_valid", vCntA - bA, 0);
        chk("t6_period_kept", ifA.period, 13);
        chk("t6_high_kept", ifA.high_time, 5);

        // async reset mid-HIGH, checked before the next clock edge
        en = 1'b1;
        pwmIn = 1'b0;
        step(5);
        pwmIn = 1'b1;
        step(6);
        rst = 1'b1;
        #1;
        chk("ar_period", ifA.period, 0);
        chk("ar_high", ifA.high_time, 0);
        chk("ar_valid", ifA.valid, 0);
        chk("ar_ovf", ifA.ovf, 0);
        chk("ar_stall", ifA.stall, 0);
        chk("ar_b_period", ifB.period, 0);
        step(2);
        rst = 1'b0;
        step(2);
        chk("valid_stall_excl", bothCnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
